// File: rtl/fifo_stream_reader.sv
// Pops words from a synchronous FIFO read port and re-presents them on a valid/ready stream.
// A small circular buffer absorbs the FIFO read latency so the stream sustains one word per cycle.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush_i,
    output logic                  flush_busy_o,
    output logic [CNT_WIDTH-1:0]  xfer_count_o
);

    localparam int BUF_DEPTH = RD_LAT + 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [OCC_W-1:0]      r_occ;
    logic                  r_ret_valid;
    logic [CNT_WIDTH-1:0]  r_xfer_count;

    logic w_room;
    logic w_capture;
    logic w_consume;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Reserve a slot for every pop still in flight so a returning word always has room.
    assign w_room       = (int'(r_occ) + int'(r_ret_valid)) < BUF_DEPTH;
    assign fifo_rd_en   = !rst && !fifo_empty && ((r_state == ST_FLUSH) || w_room);
    assign w_capture    = (r_state == ST_RUN) && ((RD_LAT == 0) ? fifo_rd_en : r_ret_valid);
    assign m_valid      = (r_occ != '0);
    assign w_consume    = m_valid && m_ready;
    assign m_data       = r_buf[r_head];
    assign flush_busy_o = (r_state == ST_FLUSH);
    assign xfer_count_o = r_xfer_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_head       <= '0;
            r_tail       <= '0;
            r_occ        <= '0;
            r_ret_valid  <= 1'b0;
            r_xfer_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_ret_valid <= (RD_LAT == 1) && fifo_rd_en;
            if (w_consume) begin
                r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
            end
            case (r_state)
                ST_RUN: begin
                    if (flush_i) begin
                        r_state <= ST_FLUSH;
                        r_occ   <= '0;
                        r_head  <= '0;
                        r_tail  <= '0;
                    end else begin
                        if (w_capture) begin
                            r_buf[r_tail] <= fifo_dout;
                            r_tail        <= ptr_inc(r_tail);
                        end
                        if (w_consume) begin
                            r_head <= ptr_inc(r_head);
                        end
                        if (w_capture && !w_consume) begin
                            r_occ <= r_occ + OCC_W'(1);
                        end else if (!w_capture && w_consume) begin
                            r_occ <= r_occ - OCC_W'(1);
                        end
                    end
                end
                // Returning words are dropped here; leave only once nothing is left upstream or in flight.
                ST_FLUSH: begin
                    if (fifo_empty && !r_ret_valid) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: two instances (RD_LAT 0 and 1) each fed by a queue-based
// FIFO model; popped words go to an expected queue that an independent monitor checks beat by beat.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    function automatic void chk(input int inst, input string nm, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL [lat%0d] %s: got 0x%0h, expected 0x%0h", inst, nm, act, req);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        localparam int          LAT   = g;
        localparam int          CW    = (g == 0) ? 16 : 4;
        localparam int          DEPTH = LAT + 2;
        localparam int unsigned CMASK = (32'd1 << CW) - 1;

        logic          rst;
        logic          fifo_empty = 1'b1;
        logic          fifo_rd_en;
        logic [7:0]    fifo_dout = 8'h00;
        logic          m_valid;
        logic          m_ready;
        logic [7:0]    m_data;
        logic          flush_i;
        logic          flush_busy_o;
        logic [CW-1:0] xfer_count_o;

        logic [7:0]  fq[$];
        logic [7:0]  exp_q[$];
        logic [7:0]  dout_reg  = 8'h00;
        logic [7:0]  prev_data = 8'h00;
        bit          mflush    = 1'b0;
        bit          ret_pend  = 1'b0;
        bit          prev_hold = 1'b0;
        bit          done_i    = 1'b0;
        int unsigned mcount    = 0;
        int          n_pops    = 0;
        event        ev_upd;

        fifo_stream_reader #(
            .DATA_WIDTH(8),
            .RD_LAT    (LAT),
            .CNT_WIDTH (CW)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .fifo_empty   (fifo_empty),
            .fifo_rd_en   (fifo_rd_en),
            .fifo_dout    (fifo_dout),
            .m_valid      (m_valid),
            .m_ready      (m_ready),
            .m_data       (m_data),
            .flush_i      (flush_i),
            .flush_busy_o (flush_busy_o),
            .xfer_count_o (xfer_count_o)
        );

        // FIFO read-port outputs, refreshed after every queue change.
        always @(ev_upd) begin
            fifo_empty = (fq.size() == 0);
            if (LAT == 0) fifo_dout = (fq.size() != 0) ? fq[0] : 8'h00;
            else          fifo_dout = dout_reg;
        end

        task automatic push(input logic [7:0] w);
            fq.push_back(w);
            -> ev_upd;
        endtask

        // Upstream FIFO plus reference model: every word popped while running and not flushed is expected downstream.
        always @(posedge clk) begin
            logic [7:0] w;
            bit         was_empty;
            was_empty = fifo_empty;
            if (rst) begin
                mflush   = 1'b0;
                ret_pend = 1'b0;
                exp_q.delete();
            end else begin
                if (fifo_rd_en) begin
                    chk(LAT, "pop_only_when_nonempty", (fq.size() != 0), 1);
                    w = 8'h00;
                    if (fq.size() != 0) w = fq.pop_front();
                    n_pops++;
                    if (LAT == 1) dout_reg = w;
                    if (!mflush && !flush_i) exp_q.push_back(w);
                end
                if (!mflush) begin
                    if (flush_i) begin
                        mflush = 1'b1;
                        exp_q.delete();
                    end
                end else if (was_empty && !ret_pend) begin
                    mflush = 1'b0;
                end
                ret_pend = (LAT == 1) && fifo_rd_en;
            end
            #1 -> ev_upd;
        end

        // Monitor: samples late in the low phase, before the edge that completes a handshake.
        always @(negedge clk) begin
            #3;
            if (rst) begin
                chk(LAT, "rst_m_valid", m_valid, 0);
                chk(LAT, "rst_rd_en", fifo_rd_en, 0);
                chk(LAT, "rst_count", xfer_count_o, 0);
                chk(LAT, "rst_busy", flush_busy_o, 0);
                mcount    = 0;
                prev_hold = 1'b0;
            end else begin
                chk(LAT, "flush_busy", flush_busy_o, mflush);
                if (mflush) chk(LAT, "valid_in_flush", m_valid, 0);
                chk(LAT, "xfer_count", xfer_count_o, mcount & CMASK);
                if (prev_hold) begin
                    chk(LAT, "hold_valid", m_valid, 1);
                    chk(LAT, "hold_data", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    chk(LAT, "beat_has_expected", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk(LAT, "m_data", m_data, exp_q.pop_front());
                    mcount++;
                end
                prev_hold = m_valid && !m_ready && !flush_i;
                prev_data = m_data;
            end
        end

        task automatic wait_idle(input string nm, input int budget);
            int k = 0;
            while (!(fq.size() == 0 && exp_q.size() == 0 && !m_valid && !flush_busy_o) && k < budget) begin
                @(negedge clk);
                k++;
            end
            chk(LAT, nm, (k < budget) ? 1 : 0, 1);
        endtask

        task automatic wait_valid(input string nm, input int budget);
            int k = 0;
            while (!m_valid && k < budget) begin
                @(negedge clk);
                k++;
            end
            chk(LAT, nm, m_valid, 1);
        endtask

        initial begin : stim
            int k;
            int p0;
            int fv;
            rst     = 1'b1;
            m_ready = 1'b0;
            flush_i = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);

            // Three words: three back-to-back pops, first beat 1+RD_LAT cycles after first pop.
            m_ready = 1'b1;
            push(8'h11); push(8'h22); push(8'h33);
            fv = -1;
            for (int i = 0; i < 4; i++) begin
                #2;
                chk(LAT, "t1_rd_en_pattern", fifo_rd_en, (i < 3) ? 1 : 0);
                if (m_valid && fv < 0) fv = i;
                @(negedge clk);
            end
            chk(LAT, "t1_first_valid_latency", fv, 1 + LAT);
            wait_idle("t1_drain", 50);
            chk(LAT, "t1_xfer_count", xfer_count_o, 3);

            // Full throughput: eight beats with no gaps.
            for (int i = 0; i < 8; i++) push(8'(i));
            wait_valid("t2_first_valid", 10);
            for (int i = 0; i < 8; i++) begin
                chk(LAT, "t2_no_gap", m_valid, 1);
                @(negedge clk);
            end
            chk(LAT, "t2_after_burst", m_valid, 0);
            wait_idle("t2_drain", 50);

            // Backpressure: pops stop once buffer plus in-flight reach capacity.
            m_ready = 1'b0;
            p0 = n_pops;
            for (int i = 0; i < 10; i++) push(8'(i));
            repeat (8) @(negedge clk);
            chk(LAT, "t3_pop_count", n_pops - p0, DEPTH);
            chk(LAT, "t3_rd_en_stalled", fifo_rd_en, 0);
            chk(LAT, "t3_valid", m_valid, 1);
            chk(LAT, "t3_head_held", m_data, 8'h00);
            m_ready = 1'b1;
            wait_idle("t3_drain", 60);

            // Flush with buffered and in-flight data, plus writes arriving during the flush.
            m_ready = 1'b0;
            for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
            repeat (2) @(negedge clk);
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
            chk(LAT, "t4_valid_dropped", m_valid, 0);
            chk(LAT, "t4_busy_set", flush_busy_o, 1);
            push(8'h50); push(8'h51);
            k = 0;
            while (flush_busy_o && k < 40) begin
                @(negedge clk);
                k++;
            end
            chk(LAT, "t4_flush_ends", flush_busy_o, 0);
            chk(LAT, "t4_fifo_drained", fq.size(), 0);
            m_ready = 1'b1;
            push(8'hAA);
            wait_valid("t4_valid_after_flush", 10);
            chk(LAT, "t4_next_data", m_data, 8'hAA);
            wait_idle("t4_drain", 50);

            // Counter wrap after 17 transfers from reset.
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 17; i++) push(8'($urandom));
            wait_idle("t5_drain", 80);
            chk(LAT, "t5_count_wrap", xfer_count_o, 17 & CMASK);

            // Reset while words are buffered.
            m_ready = 1'b0;
            for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
            repeat (4) @(negedge clk);
            chk(LAT, "t6_valid_before", m_valid, 1);
            rst = 1'b1;
            #1;
            chk(LAT, "t6_async_valid", m_valid, 0);
            chk(LAT, "t6_async_rd_en", fifo_rd_en, 0);
            chk(LAT, "t6_async_count", xfer_count_o, 0);
            chk(LAT, "t6_async_data", m_data, 8'h00);
            @(negedge clk);
            @(negedge clk);
            rst     = 1'b0;
            m_ready = 1'b1;
            wait_idle("t6_recover", 60);

            // Random traffic, backpressure and occasional flushes.
            for (int i = 0; i < 1000; i++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                flush_i = ($urandom_range(0, 80) == 0);
                if (fq.size() < 12 && $urandom_range(0, 1) == 0) push(8'($urandom));
                @(negedge clk);
            end
            flush_i = 1'b0;
            m_ready = 1'b1;
            wait_idle("t7_drain", 200);
            done_i = 1'b1;
        end
    end

    initial begin
        int k = 0;
        while (!(gen_inst[0].done_i && gen_inst[1].done_i) && k < 60000) begin
            @(posedge clk);
            k++;
        end
        chk(9, "test_timeout", (k < 60000) ? 1 : 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
